// File: rtl/pingpong_scoreboard.sv
// Pingpong scoreboard: turns rally outcomes into BCD point events, decides the winner,
// and drives a 4-digit multiplexed 7-segment display where the loser's digits blink.
module pingpong_scoreboard #(
    parameter int WIN_SCORE      = 11,
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int BLINK_DIV      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rally_state,
    input  logic       new_game,
    output logic [7:0] score_self,
    output logic [7:0] score_enemy,
    output logic       game_over,
    output logic       winner,
    output logic [3:0] an,
    output logic [7:0] seg
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [6:0] WIN = 7'(WIN_SCORE);

    logic [1:0]    prev_state;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        if (b == 8'h99)
            return b;
        else if (b[3:0] == 4'd9)
            return {b[7:4] + 4'd1, 4'd0};
        else
            return {b[7:4], b[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return {3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]};
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    logic       self_pt, enemy_pt, self_wins, enemy_wins;
    logic [7:0] self_nxt, enemy_nxt;
    logic [6:0] self_bin, enemy_bin;

    // Win test runs on the post-increment scores so the deciding point and game_over share an edge.
    always_comb begin
        self_pt    = !game_over && rally_state == 2'b01 && wait_cnt == WW'(TIMEOUT_CYCLES - 1);
        enemy_pt   = !game_over && prev_state == 2'b11 && rally_state == 2'b00;
        self_nxt   = self_pt  ? bcd_inc(score_self)  : score_self;
        enemy_nxt  = enemy_pt ? bcd_inc(score_enemy) : score_enemy;
        self_bin   = bcd_to_bin(self_nxt);
        enemy_bin  = bcd_to_bin(enemy_nxt);
        self_wins  = self_pt && (self_nxt == 8'h99 ||
                     (self_bin >= WIN && self_bin >= enemy_bin + 7'd2));
        enemy_wins = enemy_pt && (enemy_nxt == 8'h99 ||
                     (enemy_bin >= WIN && enemy_bin >= self_bin + 7'd2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state <= 2'b00;
            wait_cnt   <= '0;
        end else begin
            prev_state <= rally_state;
            if (rally_state != 2'b01)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(TIMEOUT_CYCLES))
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_self  <= 8'h00;
            score_enemy <= 8'h00;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else if (new_game) begin
            score_self  <= 8'h00;
            score_enemy <= 8'h00;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            score_self  <= self_nxt;
            score_enemy <= enemy_nxt;
            if (self_wins) begin
                game_over <= 1'b1;
                winner    <= 1'b1;
            end else if (enemy_wins) begin
                game_over <= 1'b1;
                winner    <= 1'b0;
            end
        end
    end

    logic scan_wrap, round_wrap, blink_wrap;
    assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    assign round_wrap = scan_wrap && digit_idx == 2'd3;
    assign blink_wrap = round_wrap && blink_cnt == BW'(BLINK_DIV - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt    <= '0;
            digit_idx   <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
            if (scan_wrap)
                digit_idx <= digit_idx + 2'd1;
            if (round_wrap)
                blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
            if (new_game)
                blink_phase <= 1'b0;
            else if (blink_wrap)
                blink_phase <= ~blink_phase;
        end
    end

    logic [3:0] digit_bcd;
    logic       is_tens, self_digit, blank;
    logic [7:0] seg_nxt;

    always_comb begin
        digit_bcd  = score_enemy[3:0];
        is_tens    = 1'b0;
        self_digit = 1'b0;
        case (digit_idx)
            2'd3: begin digit_bcd = score_self[7:4];  is_tens = 1'b1; self_digit = 1'b1; end
            2'd2: begin digit_bcd = score_self[3:0];  self_digit = 1'b1; end
            2'd1: begin digit_bcd = score_enemy[7:4]; is_tens = 1'b1; end
            default: digit_bcd = score_enemy[3:0];
        endcase
        // The loser is whichever side is not the winner.
        blank   = (is_tens && digit_bcd == 4'd0) ||
                  (game_over && blink_phase && (self_digit != winner));
        seg_nxt = blank ? 8'hFF : seg_of(digit_bcd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1110;
            seg <= 8'hC0;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_pingpong_scoreboard.sv
// Bench: two scoreboards (WIN_SCORE 3 and 99) share stimulus and are checked every cycle
// against a score/timing model built from plain integer arithmetic.
module tb_pingpong_scoreboard;
    localparam int T  = 8;
    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rally_state = 2'b00;
    logic       new_game = 1'b0;
    logic [7:0] ss [2];
    logic [7:0] se [2];
    logic       go [2];
    logic       win [2];
    logic [3:0] an [2];
    logic [7:0] seg [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pingpong_scoreboard #(.WIN_SCORE(3), .TIMEOUT_CYCLES(T), .SCAN_DIV(SD), .BLINK_DIV(BD)) u0 (
        .clk(clk), .reset(reset), .rally_state(rally_state), .new_game(new_game),
        .score_self(ss[0]), .score_enemy(se[0]), .game_over(go[0]), .winner(win[0]),
        .an(an[0]), .seg(seg[0]));

    pingpong_scoreboard #(.WIN_SCORE(99), .TIMEOUT_CYCLES(T), .SCAN_DIV(SD), .BLINK_DIV(BD)) u1 (
        .clk(clk), .reset(reset), .rally_state(rally_state), .new_game(new_game),
        .score_self(ss[1]), .score_enemy(se[1]), .game_over(go[1]), .winner(win[1]),
        .an(an[1]), .seg(seg[1]));

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int win_of(input int k);
        return (k == 0) ? 3 : 99;
    endfunction

    function automatic logic [7:0] enc(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] disp(input int s, input int e, input bit g, input bit w,
                                        input bit ph, input int idx);
        int d;
        bit tens, selfd;
        tens  = (idx == 3 || idx == 1);
        selfd = (idx >= 2);
        d = selfd ? s : e;
        d = tens ? d / 10 : d % 10;
        if ((tens && d == 0) || (g && ph && selfd != w))
            return 8'hFF;
        return enc(d);
    endfunction

    // Reference model: scores as integers, wait run length, and display position derived
    // from the number of clock edges since reset.
    int         m_self [2];
    int         m_enemy [2];
    bit         m_go [2];
    bit         m_win [2];
    logic [3:0] m_an [2];
    logic [7:0] m_seg [2];
    int         run = 0;
    int         prev = 0;
    int         t = 0;
    bit         phase = 1'b0;

    always @(posedge clk or posedge reset) begin : model
        int idx, s, e;
        bit g, w;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_self[k] <= 0; m_enemy[k] <= 0; m_go[k] <= 1'b0; m_win[k] <= 1'b0;
                m_an[k] <= 4'b1110; m_seg[k] <= 8'hC0;
            end
            run <= 0; prev <= 0; t <= 0; phase <= 1'b0;
        end else begin
            idx = (t / SD) % 4;
            for (int k = 0; k < 2; k++) begin
                m_an[k]  <= ~(4'b0001 << idx);
                m_seg[k] <= disp(m_self[k], m_enemy[k], m_go[k], m_win[k], phase, idx);
                s = m_self[k]; e = m_enemy[k]; g = m_go[k]; w = m_win[k];
                if (new_game) begin
                    s = 0; e = 0; g = 1'b0; w = 1'b0;
                end else if (!g) begin
                    if (rally_state == 2'b01 && run + 1 == T) begin
                        s = (s == 99) ? 99 : s + 1;
                        if (s == 99 || (s >= win_of(k) && s - e >= 2)) begin g = 1'b1; w = 1'b1; end
                    end
                    if (prev == 3 && rally_state == 2'b00) begin
                        e = (e == 99) ? 99 : e + 1;
                        if (e == 99 || (e >= win_of(k) && e - s >= 2)) begin g = 1'b1; w = 1'b0; end
                    end
                end
                m_self[k] <= s; m_enemy[k] <= e; m_go[k] <= g; m_win[k] <= w;
            end
            run   <= (rally_state == 2'b01) ? run + 1 : 0;
            phase <= new_game ? 1'b0 : (((t + 1) % (4 * SD * BD)) == 0) ? ~phase : phase;
            prev  <= int'(rally_state);
            t     <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                check("score_self", k, 32'(ss[k]), 32'(to_bcd(m_self[k])));
                check("score_enemy", k, 32'(se[k]), 32'(to_bcd(m_enemy[k])));
                check("game_over", k, 32'(go[k]), 32'(m_go[k]));
                if (m_go[k])
                    check("winner", k, 32'(win[k]), 32'(m_win[k]));
                check("an", k, 32'(an[k]), 32'(m_an[k]));
                check("seg", k, 32'(seg[k]), 32'(m_seg[k]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] s, input int n);
        rally_state = s;
        cyc(n);
    endtask

    task automatic enemy_point();
        hold(2'b11, 1);
        hold(2'b00, 1);
    endtask

    task automatic self_point();
        hold(2'b01, T);
        hold(2'b00, 1);
    endtask

    task automatic ng();
        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_an [4];
        logic [7:0] exp_seg [4];
        int ff_cnt, b0_cnt, self_blank;
        bit found;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{8'h92, 8'hFF, 8'hA4, 8'hF9};

        cyc(3);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_self", k, 32'(ss[k]), 32'h00);
            check("rst_enemy", k, 32'(se[k]), 32'h00);
            check("rst_go", k, 32'(go[k]), 32'h0);
            check("rst_an", k, 32'(an[k]), 32'he);
            check("rst_seg", k, 32'(seg[k]), 32'hc0);
        end

        // Enemy point and non-point transitions
        enemy_point();
        check("enemy_pt", 0, 32'(se[0]), 32'h01);
        hold(2'b00, 2); hold(2'b10, 1); hold(2'b00, 2);
        check("no_enemy_pt", 0, 32'(se[0]), 32'h01);

        // Timeout
        hold(2'b01, 7); hold(2'b10, 1);
        check("timeout_short", 0, 32'(ss[0]), 32'h00);
        hold(2'b01, T);
        check("timeout_fire", 0, 32'(ss[0]), 32'h01);
        hold(2'b01, 12);
        check("timeout_once", 0, 32'(ss[0]), 32'h01);
        hold(2'b00, 1);

        // Win with deuce on the WIN_SCORE=3 instance
        ng();
        enemy_point(); enemy_point();
        self_point(); self_point(); self_point();
        check("go_3_2", 0, 32'(go[0]), 32'h0);
        enemy_point(); self_point();
        check("go_4_3", 0, 32'(go[0]), 32'h0);
        self_point();
        check("go_5_3", 0, 32'(go[0]), 32'h1);
        check("win_5_3", 0, 32'(win[0]), 32'h1);
        check("self_5_3", 0, 32'(ss[0]), 32'h05);
        check("enemy_5_3", 0, 32'(se[0]), 32'h03);
        enemy_point();
        check("enemy_frozen", 0, 32'(se[0]), 32'h03);

        // Blink: enemy ones (3) alternates with blank, self ones (5) never blanks
        ff_cnt = 0; b0_cnt = 0; self_blank = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (an[0] == 4'b1110 && seg[0] == 8'hFF) ff_cnt++;
            if (an[0] == 4'b1110 && seg[0] == 8'hB0) b0_cnt++;
            if (an[0] == 4'b1011 && seg[0] == 8'hFF) self_blank++;
        end
        check("blink_seen", 0, 32'(ff_cnt > 0), 32'h1);
        check("unblink_seen", 0, 32'(b0_cnt > 0), 32'h1);
        check("winner_no_blink", 0, 32'(self_blank), 32'h0);

        // Display sequence for 12 : 05 on the WIN_SCORE=99 instance
        ng();
        repeat (5) enemy_point();
        repeat (12) self_point();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (an[1] == 4'b1110) found = 1'b1;
            else cyc(1);
        end
        check("scan_align", 1, 32'(found), 32'h1);
        for (int s = 0; s < 4; s++) begin
            check("disp_an", 1, 32'(an[1]), 32'(exp_an[s]));
            check("disp_seg", 1, 32'(seg[1]), 32'(exp_seg[s]));
            cyc(SD);
        end

        // BCD carry and saturation
        ng();
        repeat (10) self_point();
        check("bcd_10", 1, 32'(ss[1]), 32'h10);
        repeat (89) self_point();
        check("sat_99", 1, 32'(ss[1]), 32'h99);
        check("sat_go", 1, 32'(go[1]), 32'h1);
        check("sat_win", 1, 32'(win[1]), 32'h1);
        self_point();
        check("sat_hold", 1, 32'(ss[1]), 32'h99);

        // new_game coincident with an enemy point
        hold(2'b11, 1);
        rally_state = 2'b00; new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("ng_self", k, 32'(ss[k]), 32'h00);
            check("ng_enemy", k, 32'(se[k]), 32'h00);
            check("ng_go", k, 32'(go[k]), 32'h0);
        end

        // Asynchronous reset in the middle of a timeout
        enemy_point();
        hold(2'b01, 5);
        #2 reset = 1'b1;
        #1;
        check("areset_an", 0, 32'(an[0]), 32'he);
        check("areset_seg", 0, 32'(seg[0]), 32'hc0);
        check("areset_enemy", 0, 32'(se[0]), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        hold(2'b01, T - 1);
        check("areset_restart", 0, 32'(ss[0]), 32'h00);
        hold(2'b01, 1);
        check("areset_fire", 0, 32'(ss[0]), 32'h01);
        hold(2'b00, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
